// File: rtl/rc4_pkg.sv
// Shared types for the RC4 phase sequencer: controller state encoding and S-RAM owner select.
package rc4_pkg;

    localparam int unsigned KEY_WIDTH_DEFAULT = 24;

    typedef logic [3:0] state_t;

    localparam state_t StIdle     = 4'd0;
    localparam state_t StInitGo   = 4'd1;
    localparam state_t StInitWait = 4'd2;
    localparam state_t StShufGo   = 4'd3;
    localparam state_t StShufWait = 4'd4;
    localparam state_t StDecGo    = 4'd5;
    localparam state_t StDecWait  = 4'd6;
    localparam state_t StNextKey  = 4'd7;
    localparam state_t StDoneOk   = 4'd8;
    localparam state_t StDoneFail = 4'd9;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INIT,
        OWN_SHUF,
        OWN_DEC
    } owner_t;

endpackage

// File: rtl/s_mem_mux.sv
// Combinational S-RAM port select: forwards only the owning client's address, data and write
// enable; with no owner the port is idle.
module s_mem_mux
    import rc4_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  owner_t                owner,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic [DATA_WIDTH-1:0] init_data,
    input  logic                  init_wren,
    input  logic [ADDR_WIDTH-1:0] shuf_addr,
    input  logic [DATA_WIDTH-1:0] shuf_data,
    input  logic                  shuf_wren,
    input  logic [ADDR_WIDTH-1:0] dec_addr,
    input  logic [DATA_WIDTH-1:0] dec_data,
    input  logic                  dec_wren,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_wren
);

    always_comb begin
        s_addr = '0;
        s_data = '0;
        s_wren = 1'b0;
        unique case (owner)
            OWN_INIT: begin
                s_addr = init_addr;
                s_data = init_data;
                s_wren = init_wren;
            end
            OWN_SHUF: begin
                s_addr = shuf_addr;
                s_data = shuf_data;
                s_wren = shuf_wren;
            end
            OWN_DEC: begin
                s_addr = dec_addr;
                s_data = dec_data;
                s_wren = dec_wren;
            end
            OWN_NONE: ;
        endcase
    end

endmodule

// File: rtl/rc4_phase_sequencer.sv
// RC4 top controller: sequences init-fill, KSA shuffle and PRGA decrypt, owns the S-RAM grant
// and the secret key, and in crack mode walks the key upward until a decrypt succeeds.
module rc4_phase_sequencer
    import rc4_pkg::*;
#(
    parameter int unsigned          KEY_WIDTH  = KEY_WIDTH_DEFAULT,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX    = KEY_WIDTH'(24'h3FFFFF),
    parameter int unsigned          ADDR_WIDTH = 8,
    parameter int unsigned          DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  crack_en,
    input  logic [KEY_WIDTH-1:0]  key_in,
    output logic                  init_start,
    input  logic                  init_done,
    output logic                  shuf_start,
    input  logic                  shuf_done,
    output logic                  dec_start,
    input  logic                  dec_done,
    input  logic                  dec_ok,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic [DATA_WIDTH-1:0] init_data,
    input  logic                  init_wren,
    input  logic [ADDR_WIDTH-1:0] shuf_addr,
    input  logic [DATA_WIDTH-1:0] shuf_data,
    input  logic                  shuf_wren,
    input  logic [ADDR_WIDTH-1:0] dec_addr,
    input  logic [DATA_WIDTH-1:0] dec_data,
    input  logic                  dec_wren,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_wren,
    output logic [KEY_WIDTH-1:0]  secret_key,
    output logic                  busy,
    output logic                  done,
    output logic                  key_found,
    output logic                  key_exhausted
);

    state_t               state_q, state_d;
    owner_t               owner_q, owner_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 crack_q, crack_d;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        key_d   = key_q;
        crack_d = crack_q;
        case (state_q)
            StIdle, StDoneOk, StDoneFail: begin
                if (start) begin
                    key_d   = key_in;
                    crack_d = crack_en;
                    state_d = StInitGo;
                    owner_d = OWN_INIT;
                end
            end
            StInitGo:   state_d = StInitWait;
            StInitWait: begin
                if (init_done) begin
                    state_d = StShufGo;
                    owner_d = OWN_SHUF;
                end
            end
            StShufGo:   state_d = StShufWait;
            StShufWait: begin
                if (shuf_done) begin
                    state_d = StDecGo;
                    owner_d = OWN_DEC;
                end
            end
            StDecGo:    state_d = StDecWait;
            StDecWait: begin
                if (dec_done) begin
                    if (dec_ok) begin
                        state_d = StDoneOk;
                        owner_d = OWN_NONE;
                    end else if (crack_q && (key_q < KEY_MAX)) begin
                        // Decrypt keeps the port until the next init-fill claims it.
                        state_d = StNextKey;
                    end else begin
                        state_d = StDoneFail;
                        owner_d = OWN_NONE;
                    end
                end
            end
            StNextKey: begin
                key_d   = key_q + KEY_WIDTH'(1);
                state_d = StInitGo;
                owner_d = OWN_INIT;
            end
            default: begin
                state_d = StIdle;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= OWN_NONE;
            key_q   <= '0;
            crack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            key_q   <= key_d;
            crack_q <= crack_d;
        end
    end

    always_comb begin
        init_start    = (state_q == StInitGo);
        shuf_start    = (state_q == StShufGo);
        dec_start     = (state_q == StDecGo);
        busy          = (state_q >= StInitGo) && (state_q <= StNextKey);
        key_found     = (state_q == StDoneOk);
        key_exhausted = (state_q == StDoneFail);
        done          = key_found || key_exhausted;
        secret_key    = key_q;
    end

    s_mem_mux #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_s_mem_mux (
        .owner    (owner_q),
        .init_addr(init_addr),
        .init_data(init_data),
        .init_wren(init_wren),
        .shuf_addr(shuf_addr),
        .shuf_data(shuf_data),
        .shuf_wren(shuf_wren),
        .dec_addr (dec_addr),
        .dec_data (dec_data),
        .dec_wren (dec_wren),
        .s_addr   (s_addr),
        .s_data   (s_data),
        .s_wren   (s_wren)
    );

endmodule
